// File: rtl/vga_fetch.sv
// vga_fetch: VGA read front end. Converts (h, v) fetch requests into ZBT word
// addresses in the displayed buffer, arbitrates for the memory port, returns
// the word with a one-cycle done strobe, and swaps display buffers during
// vertical blanking once the writer has finished a frame.
module vga_fetch #(
  parameter int DATA_W    = 36,
  parameter int ADDR_W    = 19,
  parameter int HWORDS    = 320,
  parameter int VLINES    = 480,
  parameter int BUF1_BASE = 153600,
  parameter int MEM_LAT   = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_flag,
  input  logic              vga_flag,
  input  logic [9:0]        clocked_hcount,
  input  logic [9:0]        clocked_vcount,
  output logic [DATA_W-1:0] vga_pixel,
  output logic              done_vga,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_grant,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              display_buf,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam int          CNT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [9:0]  HPIX   = 10'(HWORDS * 2);
  localparam logic [9:0]  VLIM   = 10'(VLINES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   pixel_q, pixel_d;
  logic                done_q, done_d;
  logic                disp_q, disp_d;
  logic                overrun_q, overrun_d;
  logic                swap_pending_q, swap_pending_d;

  logic                accept, in_range, vblank;
  logic [ADDR_W-1:0]   v_ext, base, req_addr;

  // Word address of the incoming request: base + v*320 + h/2.
  always_comb begin
    v_ext    = ADDR_W'(clocked_vcount);
    base     = disp_q ? ADDR_W'(BUF1_BASE) : '0;
    req_addr = base + (v_ext << 8) + (v_ext << 6) + ADDR_W'(clocked_hcount[9:1]);
    in_range = (clocked_vcount < VLIM) && (clocked_hcount < HPIX);
    vblank   = (clocked_vcount >= VLIM);
    accept   = vga_flag && (state_q == IDLE || state_q == DONE);
  end

  // Next-state logic for the fetch FSM, buffer swap and overrun flag.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    mem_req_d      = mem_req_q;
    mem_addr_d     = mem_addr_q;
    pixel_d        = pixel_q;
    done_d         = 1'b0;
    disp_d         = disp_q;
    overrun_d      = overrun_q;
    swap_pending_d = swap_pending_q;

    case (state_q)
      IDLE, DONE: state_d = IDLE;
      REQ: begin
        if (mem_grant) begin
          state_d   = WAIT;
          mem_req_d = 1'b0;
          cnt_d     = '0;
        end
        if (vga_flag) overrun_d = 1'b1;
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          pixel_d = mem_rdata;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (vga_flag) overrun_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Address uses the buffer in effect before any swap this request causes.
    if (accept) begin
      mem_addr_d = req_addr;
      if (in_range) begin
        state_d   = REQ;
        mem_req_d = 1'b1;
      end else begin
        state_d = DONE;
        done_d  = 1'b1;
        pixel_d = '0;
      end
      if (vblank && swap_pending_q) begin
        disp_d         = ~disp_q;
        swap_pending_d = 1'b0;
      end
    end

    // A frame completing in the swap cycle re-arms the next swap.
    if (frame_flag) swap_pending_d = 1'b1;
  end

  // State and registered outputs; reset aborts any transaction at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      mem_req_q      <= 1'b0;
      mem_addr_q     <= '0;
      pixel_q        <= '0;
      done_q         <= 1'b0;
      disp_q         <= 1'b0;
      overrun_q      <= 1'b0;
      swap_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mem_req_q      <= mem_req_d;
      mem_addr_q     <= mem_addr_d;
      pixel_q        <= pixel_d;
      done_q         <= done_d;
      disp_q         <= disp_d;
      overrun_q      <= overrun_d;
      swap_pending_q <= swap_pending_d;
    end
  end

  assign vga_pixel   = pixel_q;
  assign done_vga    = done_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign display_buf = disp_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_vga_fetch.sv
// Directed bench for vga_fetch: latency, addressing, grant stall, out-of-range,
// buffer swap, back-to-back, overrun and asynchronous reset.
module tb_vga_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        frame_flag = 1'b0;
  logic        vga_flag = 1'b0;
  logic [9:0]  clocked_hcount = '0;
  logic [9:0]  clocked_vcount = '0;
  logic [35:0] vga_pixel;
  logic        done_vga;
  logic        mem_req;
  logic [18:0] mem_addr;
  logic        mem_grant = 1'b0;
  logic [35:0] mem_rdata = '0;
  logic        display_buf;
  logic        overrun;

  int n_cmp = 0;
  int n_bad = 0;

  vga_fetch dut (
    .clock(clock), .reset(reset), .frame_flag(frame_flag), .vga_flag(vga_flag),
    .clocked_hcount(clocked_hcount), .clocked_vcount(clocked_vcount),
    .vga_pixel(vga_pixel), .done_vga(done_vga), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_grant(mem_grant), .mem_rdata(mem_rdata),
    .display_buf(display_buf), .overrun(overrun)
  );

  always #5 clock = ~clock;

  // Advance one cycle; outputs are then stable for the new cycle.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Pulse vga_flag for one cycle (cycle F); returns in cycle F+1.
  task automatic flag(input logic [9:0] h, input logic [9:0] v);
    vga_flag = 1'b1; clocked_hcount = h; clocked_vcount = v;
    step();
    vga_flag = 1'b0;
  endtask

  // Step until done_vga, bounded; cycles = -1 on timeout.
  task automatic wait_done(input int budget, output int cycles);
    cycles = -1;
    for (int i = 0; i < budget; i++) begin
      if (done_vga === 1'b1) begin cycles = i; break; end
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; step(); #2;
    n_cmp++;
    if ({mem_req, mem_addr, vga_pixel, done_vga, display_buf, overrun} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got req=%b addr=%0d pix=%h done=%b buf=%b ovr=%b want all 0",
               mem_req, mem_addr, vga_pixel, done_vga, display_buf, overrun);
    end
    reset = 1'b0; step();
  endtask

  task automatic test_basic();
    mem_grant = 1'b1; mem_rdata = 36'hFFFFFFFFF;
    flag(10'd0, 10'd0);                              // F+1
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 19'd0) begin
      n_bad++; $display("FAIL basic_req: got req=%b addr=%0d want 1/0", mem_req, mem_addr);
    end
    step();                                          // F+2
    n_cmp++;
    if (mem_req !== 1'b0) begin n_bad++; $display("FAIL basic_req_drop: got %b want 0", mem_req); end
    step();                                          // F+3
    mem_rdata = 36'h123456789;
    n_cmp++;
    if (done_vga !== 1'b0) begin n_bad++; $display("FAIL basic_early_done: got %b want 0", done_vga); end
    step();                                          // F+4
    mem_rdata = 36'hFFFFFFFFF;
    n_cmp++;
    if (done_vga !== 1'b1 || vga_pixel !== 36'h123456789) begin
      n_bad++; $display("FAIL basic_done: got done=%b pix=%h want 1/123456789", done_vga, vga_pixel);
    end
    step();                                          // F+5
    n_cmp++;
    if (done_vga !== 1'b0 || vga_pixel !== 36'h123456789) begin
      n_bad++; $display("FAIL basic_hold: got done=%b pix=%h want 0/123456789", done_vga, vga_pixel);
    end
  endtask

  task automatic test_max_addr();
    int c;
    mem_grant = 1'b1; mem_rdata = 36'h0AAAA5555;
    flag(10'd639, 10'd479);
    n_cmp++;
    if (mem_addr !== 19'd153599) begin n_bad++; $display("FAIL max_addr: got %0d want 153599", mem_addr); end
    wait_done(10, c);
    n_cmp++;
    if (c != 3 || vga_pixel !== 36'h0AAAA5555) begin
      n_bad++; $display("FAIL max_done: got wait=%0d pix=%h want 3/0AAAA5555", c, vga_pixel);
    end
    step();
  endtask

  task automatic test_grant_wait();
    int bad_hold = 0;
    mem_grant = 1'b0; mem_rdata = 36'h0;
    flag(10'd5, 10'd2);                              // F+1, addr 2*320+2 = 642
    for (int i = 0; i < 3; i++) begin                // F+1..F+3, no grant
      if (mem_req !== 1'b1 || mem_addr !== 19'd642) bad_hold++;
      step();
    end
    mem_grant = 1'b1;                                // grant in F+4
    n_cmp++;
    if (bad_hold != 0 || mem_req !== 1'b1 || mem_addr !== 19'd642) begin
      n_bad++; $display("FAIL stall_hold: got bad=%0d req=%b addr=%0d want 0/1/642", bad_hold, mem_req, mem_addr);
    end
    step();                                          // F+5
    mem_grant = 1'b0;
    n_cmp++;
    if (mem_req !== 1'b0) begin n_bad++; $display("FAIL stall_single_grant: got req=%b want 0", mem_req); end
    step();                                          // F+6 = grant+2
    mem_rdata = 36'h0DEADBEEF;
    n_cmp++;
    if (done_vga !== 1'b0) begin n_bad++; $display("FAIL stall_early_done: got %b want 0", done_vga); end
    step();                                          // F+7
    mem_rdata = 36'h0;
    n_cmp++;
    if (done_vga !== 1'b1 || vga_pixel !== 36'h0DEADBEEF) begin
      n_bad++; $display("FAIL stall_done: got done=%b pix=%h want 1/0DEADBEEF", done_vga, vga_pixel);
    end
    step();
  endtask

  task automatic test_out_of_range();
    mem_grant = 1'b1;
    flag(10'd0, 10'd500);                            // F+1
    n_cmp++;
    if (done_vga !== 1'b1 || vga_pixel !== 36'h0 || mem_req !== 1'b0) begin
      n_bad++; $display("FAIL oor_v: got done=%b pix=%h req=%b want 1/0/0", done_vga, vga_pixel, mem_req);
    end
    step();
    flag(10'd700, 10'd5);
    n_cmp++;
    if (done_vga !== 1'b1 || mem_req !== 1'b0) begin
      n_bad++; $display("FAIL oor_h: got done=%b req=%b want 1/0", done_vga, mem_req);
    end
    step();
  endtask

  task automatic test_swap();
    int c;
    mem_grant = 1'b1; mem_rdata = 36'h1;
    frame_flag = 1'b1; step(); frame_flag = 1'b0;
    flag(10'd0, 10'd10);
    wait_done(10, c); step();
    n_cmp++;
    if (display_buf !== 1'b0) begin n_bad++; $display("FAIL swap_visible_line: got %b want 0", display_buf); end
    flag(10'd0, 10'd480);
    n_cmp++;
    if (display_buf !== 1'b1 || done_vga !== 1'b1) begin
      n_bad++; $display("FAIL swap_vblank: got buf=%b done=%b want 1/1", display_buf, done_vga);
    end
    step();
    flag(10'd0, 10'd0);
    n_cmp++;
    if (mem_addr !== 19'd153600) begin n_bad++; $display("FAIL swap_addr: got %0d want 153600", mem_addr); end
    wait_done(10, c); step();
    // No pending swap: vblank request leaves the buffer alone.
    flag(10'd0, 10'd481); step();
    n_cmp++;
    if (display_buf !== 1'b1) begin n_bad++; $display("FAIL swap_no_pending: got %b want 1", display_buf); end
    // Frame flag coincident with a swap keeps the next swap armed.
    frame_flag = 1'b1; step();
    frame_flag = 1'b1; vga_flag = 1'b1; clocked_vcount = 10'd480; step();
    frame_flag = 1'b0; vga_flag = 1'b0;
    n_cmp++;
    if (display_buf !== 1'b0) begin n_bad++; $display("FAIL swap_coincident: got %b want 0", display_buf); end
    step();
    flag(10'd0, 10'd490);
    n_cmp++;
    if (display_buf !== 1'b1) begin n_bad++; $display("FAIL swap_rearmed: got %b want 1", display_buf); end
    step();
  endtask

  task automatic test_back_to_back();
    mem_grant = 1'b1; mem_rdata = 36'h0CAFE0000;
    flag(10'd2, 10'd0);                              // F+1
    step(); step(); step();                          // F+4, DONE
    n_cmp++;
    if (done_vga !== 1'b1) begin n_bad++; $display("FAIL b2b_first_done: got %b want 1", done_vga); end
    mem_rdata = 36'h0CAFE0001;
    flag(10'd4, 10'd0);                              // F+5
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 19'd153602) begin
      n_bad++; $display("FAIL b2b_second_req: got req=%b addr=%0d want 1/153602", mem_req, mem_addr);
    end
    step(); step(); step();                          // F+8
    n_cmp++;
    if (done_vga !== 1'b1 || vga_pixel !== 36'h0CAFE0001) begin
      n_bad++; $display("FAIL b2b_second_done: got done=%b pix=%h want 1/0CAFE0001", done_vga, vga_pixel);
    end
    step();
  endtask

  task automatic test_overrun_reset();
    int dones = 0;
    mem_grant = 1'b1; mem_rdata = 36'h0BEEF;
    flag(10'd0, 10'd0);                              // F+1
    step();                                          // F+2 (WAIT)
    flag(10'd0, 10'd1);                              // dropped
    for (int i = 0; i < 8; i++) begin
      if (done_vga === 1'b1) dones++;
      step();
    end
    n_cmp++;
    if (dones != 1 || overrun !== 1'b1) begin
      n_bad++; $display("FAIL overrun_drop: got dones=%0d ovr=%b want 1/1", dones, overrun);
    end
    flag(10'd0, 10'd600); step();
    n_cmp++;
    if (overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
    // Reset in the middle of WAIT.
    flag(10'd8, 10'd3); step();                      // F+2 (WAIT)
    #2 reset = 1'b1; #1;
    n_cmp++;
    if ({mem_req, mem_addr, vga_pixel, done_vga, display_buf, overrun} !== '0) begin
      n_bad++; $display("FAIL reset_mid_wait: got req=%b addr=%0d pix=%h done=%b buf=%b ovr=%b want all 0",
                        mem_req, mem_addr, vga_pixel, done_vga, display_buf, overrun);
    end
    step();
    reset = 1'b0; mem_rdata = 36'h0BAD;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done_vga !== 1'b0 || mem_req !== 1'b0 || vga_pixel !== 36'h0) dones++;
    end
    n_cmp++;
    if (dones != 0) begin n_bad++; $display("FAIL reset_ignores_data: got %0d bad cycles want 0", dones); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_addr();
    test_grant_wait();
    test_out_of_range();
    test_swap();
    test_back_to_back();
    test_overrun_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
